// File: rtl/hdc_cos_encode_seq.sv
// Purpose : time-shares one cos_lookup across DIM dimensions; per dimension the angle is
//           ((sum_f feat_f*W[d][f]) >> SHIFT)[7:0] + bias_d, and the element is cos_lookup(angle).
// Latency : first enc_valid N_FEAT+2 cycles after start; N_FEAT+2 cycles per element when ready is high.
// Backpr. : enc_data/enc_idx hold in OUT until enc_ready; the sequencer stalls, nothing is dropped.
// Ports   : clk/rst_n (async active-low); start/abort/feat request side; busy/done status;
//           w_*/b_* sync-read ROM ports (data one cycle after ren); enc_* valid/ready element stream.

package cosine_pkg;

  // Quarter-wave table: round(32*cos(i*pi/128)) for i = 0..64.
  function automatic logic [5:0] cos_quarter(input logic [6:0] i);
    logic [5:0] r;
    case (i) inside
      [7'd0:7'd7]:         r = 6'd32;
      [7'd8:7'd12]:        r = 6'd31;
      [7'd13:7'd16]:       r = 6'd30;
      [7'd17:7'd19]:       r = 6'd29;
      [7'd20:7'd21]:       r = 6'd28;
      [7'd22:7'd24]:       r = 6'd27;
      [7'd25:7'd26]:       r = 6'd26;
      [7'd27:7'd28]:       r = 6'd25;
      [7'd29:7'd30]:       r = 6'd24;
      [7'd31:7'd32]:       r = 6'd23;
      7'd33:               r = 6'd22;
      [7'd34:7'd35]:       r = 6'd21;
      [7'd36:7'd37]:       r = 6'd20;
      7'd38:               r = 6'd19;
      [7'd39:7'd40]:       r = 6'd18;
      7'd41:               r = 6'd17;
      [7'd42:7'd43]:       r = 6'd16;
      7'd44:               r = 6'd15;
      [7'd45:7'd46]:       r = 6'd14;
      7'd47:               r = 6'd13;
      [7'd48:7'd49]:       r = 6'd12;
      7'd50:               r = 6'd11;
      7'd51:               r = 6'd10;
      [7'd52:7'd53]:       r = 6'd9;
      7'd54:               r = 6'd8;
      7'd55:               r = 6'd7;
      7'd56:               r = 6'd6;
      [7'd57:7'd58]:       r = 6'd5;
      7'd59:               r = 6'd4;
      7'd60:               r = 6'd3;
      [7'd61:7'd62]:       r = 6'd2;
      7'd63:               r = 6'd1;
      default:             r = 6'd0;
    endcase
    return r;
  endfunction

  // round(-32*cos(2*pi*a/256)): angle 0 maps to -32, angle 128 to +32.
  function automatic logic signed [7:0] cos_lookup(input logic [7:0] a);
    logic [6:0]        i;
    logic [6:0]        ic;
    logic signed [7:0] pos_i;
    logic signed [7:0] pos_ic;
    logic signed [7:0] r;
    i      = {1'b0, a[5:0]};
    ic     = 7'd64 - i;
    pos_i  = $signed({2'b00, cos_quarter(i)});
    pos_ic = $signed({2'b00, cos_quarter(ic)});
    case (a[7:6])
      2'd0:    r = -pos_i;
      2'd1:    r = pos_ic;
      2'd2:    r = pos_i;
      default: r = -pos_ic;
    endcase
    return r;
  endfunction

endpackage

module hdc_cos_encode_seq #(
  parameter int DIM    = 64,
  parameter int N_FEAT = 4,
  parameter int SHIFT  = 4,
  localparam int AW    = (DIM * N_FEAT > 1) ? $clog2(DIM * N_FEAT) : 1,
  localparam int DW    = (DIM > 1) ? $clog2(DIM) : 1,
  localparam int FW    = (N_FEAT > 1) ? $clog2(N_FEAT) : 1,
  localparam int ACC_W = 16 + $clog2(N_FEAT) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [8*N_FEAT-1:0]   feat,
  output logic                  busy,
  output logic                  done,
  output logic                  w_ren,
  output logic [AW-1:0]         w_addr,
  input  logic [7:0]            w_rdata,
  output logic                  b_ren,
  output logic [DW-1:0]         b_addr,
  input  logic [7:0]            b_rdata,
  output logic                  enc_valid,
  input  logic                  enc_ready,
  output logic signed [7:0]     enc_data,
  output logic [DW-1:0]         enc_idx
);

  typedef enum logic [1:0] {IDLE, RD, DRAIN, OUT} state_t;

  state_t                   state_q;
  logic [8*N_FEAT-1:0]      feat_q;
  logic [DW-1:0]            d_q;
  logic [FW-1:0]            f_q;
  logic signed [ACC_W-1:0]  acc_q;
  logic [7:0]               bias_q;
  logic                     b_vld_q;   // b_rdata carries this dimension's bias this cycle
  logic                     busy_q;
  logic                     done_q;
  logic                     w_ren_q;
  logic [AW-1:0]            w_addr_q;
  logic                     b_ren_q;
  logic [DW-1:0]            b_addr_q;
  logic                     enc_valid_q;
  logic signed [7:0]        enc_data_q;
  logic [DW-1:0]            enc_idx_q;

  // Datapath: the ROM word arriving now belongs to the previous address, so it
  // pairs with feature f-1 in RD and with the last feature in DRAIN.
  logic [FW-1:0]            fsel;
  logic signed [7:0]        feat_sel;
  logic signed [15:0]       prod;
  logic signed [ACC_W-1:0]  acc_d;
  logic [7:0]               bias_eff;
  logic [7:0]               angle_d;

  always_comb begin
    fsel     = (state_q == DRAIN) ? FW'(N_FEAT - 1) : f_q - 1'b1;
    feat_sel = $signed(feat_q[8*fsel +: 8]);
    prod     = feat_sel * $signed(w_rdata);
    acc_d    = acc_q + $signed({{(ACC_W-16){prod[15]}}, prod});
    // With N_FEAT==1 the bias word is still on the ROM bus during DRAIN.
    bias_eff = b_vld_q ? b_rdata : bias_q;
    angle_d  = acc_d[SHIFT+7:SHIFT] + bias_eff;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      feat_q      <= '0;
      d_q         <= '0;
      f_q         <= '0;
      acc_q       <= '0;
      bias_q      <= '0;
      b_vld_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      w_ren_q     <= 1'b0;
      w_addr_q    <= '0;
      b_ren_q     <= 1'b0;
      b_addr_q    <= '0;
      enc_valid_q <= 1'b0;
      enc_data_q  <= '0;
      enc_idx_q   <= '0;
    end else begin
      done_q  <= 1'b0;
      b_vld_q <= b_ren_q;
      if (b_vld_q) begin
        bias_q <= b_rdata;
      end
      if (abort) begin
        // Drops any pending element, even one being accepted this cycle.
        state_q     <= IDLE;
        busy_q      <= 1'b0;
        w_ren_q     <= 1'b0;
        b_ren_q     <= 1'b0;
        enc_valid_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (start) begin
              feat_q   <= feat;
              d_q      <= '0;
              f_q      <= '0;
              acc_q    <= '0;
              busy_q   <= 1'b1;
              w_ren_q  <= 1'b1;
              w_addr_q <= '0;
              b_ren_q  <= 1'b1;
              b_addr_q <= '0;
              state_q  <= RD;
            end
          end
          RD: begin
            b_ren_q <= 1'b0;
            if (f_q != '0) begin
              acc_q <= acc_d;
            end
            if (f_q == FW'(N_FEAT - 1)) begin
              w_ren_q <= 1'b0;
              state_q <= DRAIN;
            end else begin
              f_q      <= f_q + 1'b1;
              w_addr_q <= w_addr_q + 1'b1;
            end
          end
          DRAIN: begin
            acc_q       <= acc_d;
            enc_data_q  <= cosine_pkg::cos_lookup(angle_d);
            enc_idx_q   <= d_q;
            enc_valid_q <= 1'b1;
            state_q     <= OUT;
          end
          OUT: begin
            if (enc_ready) begin
              enc_valid_q <= 1'b0;
              if (d_q == DW'(DIM - 1)) begin
                done_q  <= 1'b1;
                busy_q  <= 1'b0;
                state_q <= IDLE;
              end else begin
                // w_addr already points at the last word of d; +1 is (d+1)*N_FEAT.
                d_q      <= d_q + 1'b1;
                f_q      <= '0;
                acc_q    <= '0;
                w_ren_q  <= 1'b1;
                w_addr_q <= w_addr_q + 1'b1;
                b_ren_q  <= 1'b1;
                b_addr_q <= d_q + 1'b1;
                state_q  <= RD;
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign w_ren     = w_ren_q;
  assign w_addr    = w_addr_q;
  assign b_ren     = b_ren_q;
  assign b_addr    = b_addr_q;
  assign enc_valid = enc_valid_q;
  assign enc_data  = enc_data_q;
  assign enc_idx   = enc_idx_q;

endmodule

// File: tb/tb_hdc_cos_encode_seq.sv
// Scoreboard bench for hdc_cos_encode_seq with DIM=4, N_FEAT=2, SHIFT=4.
// Stimulus pushes hand-computed elements; a negedge monitor pops and compares on each handshake.
module tb_hdc_cos_encode_seq;

  localparam int DIM    = 4;
  localparam int N_FEAT = 2;
  localparam int SHIFT  = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [15:0] feat;
  logic        busy;
  logic        done;
  logic        w_ren;
  logic [2:0]  w_addr;
  logic [7:0]  w_rdata;
  logic        b_ren;
  logic [1:0]  b_addr;
  logic [7:0]  b_rdata;
  logic        enc_valid;
  logic        enc_ready;
  logic signed [7:0] enc_data;
  logic [1:0]  enc_idx;

  hdc_cos_encode_seq #(.DIM(DIM), .N_FEAT(N_FEAT), .SHIFT(SHIFT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .feat(feat),
    .busy(busy), .done(done),
    .w_ren(w_ren), .w_addr(w_addr), .w_rdata(w_rdata),
    .b_ren(b_ren), .b_addr(b_addr), .b_rdata(b_rdata),
    .enc_valid(enc_valid), .enc_ready(enc_ready), .enc_data(enc_data), .enc_idx(enc_idx)
  );

  always #5 clk = ~clk;

  // Sync-read ROM models
  logic [7:0] w_mem [DIM*N_FEAT];
  logic [7:0] b_mem [DIM];
  always @(posedge clk) begin
    if (w_ren) w_rdata <= w_mem[w_addr];
    if (b_ren) b_rdata <= b_mem[b_addr];
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string name, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  typedef struct {int idx; int data; bit last;} exp_t;
  exp_t q[$];

  // Monitor / scoreboard
  bit done_pend = 0;
  bit stall_prev = 0;
  int prev_data, prev_idx;
  always @(negedge clk) begin
    if (!rst_n) begin
      done_pend  = 0;
      stall_prev = 0;
    end else begin
      if (done || done_pend) begin
        check("done_pulse", int'(done), int'(done_pend));
        done_pend = 0;
      end
      if (stall_prev && enc_valid) begin
        check("stall_data", int'(enc_data), prev_data);
        check("stall_idx", int'(enc_idx), prev_idx);
      end
      if (enc_valid && enc_ready && !abort) begin
        if (q.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL extra_element: got idx %0d data %0d, expected no element", enc_idx, enc_data);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("elem_idx", int'(enc_idx), e.idx);
          check("elem_data", int'(enc_data), e.data);
          if (e.last) done_pend = 1;
        end
      end
      stall_prev = enc_valid && !enc_ready && !abort;
      prev_data  = int'(enc_data);
      prev_idx   = int'(enc_idx);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rom(input int w0, input int w1, input int b0, input int b1,
                         input int b2, input int b3);
    for (int d = 0; d < DIM; d++) begin
      w_mem[2*d]   = 8'(w0);
      w_mem[2*d+1] = 8'(w1);
    end
    b_mem[0] = 8'(b0);
    b_mem[1] = 8'(b1);
    b_mem[2] = 8'(b2);
    b_mem[3] = 8'(b3);
  endtask

  task automatic push4(input int e0, input int e1, input int e2, input int e3);
    q.push_back('{0, e0, 1'b0});
    q.push_back('{1, e1, 1'b0});
    q.push_back('{2, e2, 1'b0});
    q.push_back('{3, e3, 1'b1});
  endtask

  task automatic run_req(input logic [15:0] f);
    feat  = f;
    start = 1'b1;
    tick();
    start = 1'b0;
    feat  = 16'hA5A5;   // only the value present at the accepted start may be used
  endtask

  task automatic wait_done(input bit rand_ready);
    int n = 0;
    while (!done && n < 500) begin
      if (rand_ready) enc_ready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    check("done_seen", int'(done), 1);
    enc_ready = 1'b1;
    tick();
    check("all_delivered", q.size(), 0);
    check("idle_after_done", int'(busy), 0);
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!enc_valid && n < 100) begin
      tick();
      n++;
    end
    check(name, int'(enc_valid), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int cnt;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; feat = '0; enc_ready = 1'b1;
    set_rom(0, 0, 0, 0, 0, 0);
    repeat (3) tick();
    check("rst_busy", int'(busy), 0);
    check("rst_valid", int'(enc_valid), 0);
    check("rst_wren", int'(w_ren), 0);
    check("rst_bren", int'(b_ren), 0);
    check("rst_done", int'(done), 0);
    rst_n = 1'b1;
    tick();

    // T1: feat=0, W=0, bias={0,64,-128,-64} -> angles 0,64,128,192 -> {-32,0,32,0}
    set_rom(0, 0, 0, 64, -128, -64);
    push4(-32, 0, 32, 0);
    run_req(16'h0000);
    check("busy_after_start", int'(busy), 1);
    cnt = 1;
    while (!enc_valid && cnt < 50) begin
      tick();
      cnt++;
    end
    check("first_valid_latency", cnt, N_FEAT + 2);
    wait_done(1'b0);

    // T2: f0=16, f1=0, W[d][0]=16, W[d][1]=99 -> acc=256, >>4 = 16 -> -30.
    // A start pulse mid-request with other features must be ignored.
    set_rom(16, 99, 0, 0, 0, 0);
    push4(-30, -30, -30, -30);
    run_req(16'h0010);
    repeat (2) tick();
    feat = 16'h7F7F; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(1'b0);

    // T3: f0=f1=127, W=127: acc=32258=0x7E02, [11:4]=0xE0=224.
    // bias {0,32,-32,100}: angles 224,0,192,68 -> {-23,-32,0,3}
    set_rom(127, 127, 0, 32, -32, 100);
    push4(-23, -32, 0, 3);
    run_req(16'h7F7F);
    wait_done(1'b0);

    // T4: f0=-16, f1=8, W=16: acc=-128, >>4 = -8 -> angle 248 -> -31; random stalls.
    set_rom(16, 16, 0, 0, 0, 0);
    push4(-31, -31, -31, -31);
    enc_ready = 1'b0;
    run_req(16'h08F0);
    wait_done(1'b1);

    // T5: abort while element 1 is pending (ready high the same cycle).
    set_rom(0, 0, 0, 64, -128, -64);
    q.push_back('{0, -32, 1'b0});
    enc_ready = 1'b0;
    run_req(16'h0000);
    wait_valid("abort_wait_v0");
    enc_ready = 1'b1;
    tick();
    enc_ready = 1'b0;
    wait_valid("abort_wait_v1");
    check("abort_pending_idx", int'(enc_idx), 1);
    abort = 1'b1; enc_ready = 1'b1;
    tick();
    abort = 1'b0; enc_ready = 1'b0;
    check("abort_busy", int'(busy), 0);
    check("abort_valid", int'(enc_valid), 0);
    repeat (6) tick();
    check("abort_valid_stays_low", int'(enc_valid), 0);
    check("abort_queue", q.size(), 0);
    enc_ready = 1'b1;
    push4(-32, 0, 32, 0);
    run_req(16'h0000);
    wait_done(1'b0);

    // T6: async reset mid-RD clears outputs immediately.
    set_rom(16, 16, 0, 0, 0, 0);
    run_req(16'h0010);
    check("rd_wren_before_reset", int'(w_ren), 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", int'(busy), 0);
    check("arst_wren", int'(w_ren), 0);
    check("arst_waddr", int'(w_addr), 0);
    check("arst_bren", int'(b_ren), 0);
    check("arst_valid", int'(enc_valid), 0);
    check("arst_done", int'(done), 0);
    check("arst_data", int'(enc_data), 0);
    check("arst_idx", int'(enc_idx), 0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (8) tick();
    check("post_reset_valid", int'(enc_valid), 0);
    push4(-30, -30, -30, -30);
    run_req(16'h0010);
    wait_done(1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
